// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles little-endian 32-bit words from a byte
// stream and writes them to consecutive word addresses while holding the core.
module imem_loader #(
  parameter int DEPTH = 32,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] num_words,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          cpu_hold
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [1:0]    state;
  logic [1:0]    byte_cnt;
  logic [AW-1:0] word_cnt;
  logic [AW-1:0] cnt_lat;
  logic [31:0]   asm_word;
  logic          hold_q;
  logic          err_q;

  logic accept;
  logic nw_zero;
  logic nw_big;

  assign accept  = in_valid && in_ready;
  assign nw_zero = (num_words == '0);
  assign nw_big  = ({1'b0, num_words} > DEPTH_W);

  assign in_ready = (state == RECV);
  assign mem_we   = (state == WRITE);
  assign busy     = (state == RECV) || (state == WRITE);
  assign done     = (state == DONE);
  assign err      = err_q;
  // hold drops in the DONE cycle itself, together with the done pulse
  assign cpu_hold = hold_q && (state != DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      byte_cnt  <= 2'd0;
      word_cnt  <= '0;
      cnt_lat   <= '0;
      asm_word  <= 32'd0;
      mem_waddr <= '0;
      mem_wdata <= 32'd0;
      hold_q    <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (nw_big) begin
              err_q <= 1'b1;
            end else begin
              hold_q   <= 1'b1;
              cnt_lat  <= num_words;
              word_cnt <= '0;
              byte_cnt <= 2'd0;
              state    <= nw_zero ? DONE : RECV;
            end
          end
        end
        RECV: begin
          if (accept) begin
            asm_word[{byte_cnt, 3'b000} +: 8] <= in_data;
            byte_cnt <= byte_cnt + 2'd1;
            // the last byte bypasses the assembly register so WRITE sees the full word
            if (byte_cnt == 2'd3) begin
              mem_waddr <= word_cnt;
              mem_wdata <= {in_data, asm_word[23:0]};
              state     <= WRITE;
            end
          end
        end
        WRITE: begin
          word_cnt <= word_cnt + AW'(1);
          state    <= ((word_cnt + AW'(1)) == cnt_lat) ? DONE : RECV;
        end
        default: begin
          hold_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The module SHALL have parameter DEPTH, default 32, giving the number of 32-bit instruction memory words.
REQ-002 The module SHALL have parameter AW, default 8, giving the word-address width.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit wide: reset, synchronous, active-low.
REQ-005 Port start SHALL be an input, 1 bit wide: a 1-cycle request to begin a load, honoured in IDLE only.
REQ-006 Port num_words SHALL be an input, AW bits wide: the word count, sampled on the cycle start is accepted.
REQ-007 Port in_valid SHALL be an input, 1 bit wide: the byte stream source has data.
REQ-008 Port in_data SHALL be an input, 8 bits wide: the stream byte.
REQ-009 Port in_ready SHALL be an output, 1 bit wide: the loader accepts a byte; a transfer occurs when in_valid and in_ready are both high.
REQ-010 Port mem_we SHALL be an output, 1 bit wide: the instruction memory write strobe.
REQ-011 Port mem_waddr SHALL be an output, AW bits wide: the word address written.
REQ-012 Port mem_wdata SHALL be an output, 32 bits wide: the instruction word written.
REQ-013 Port busy SHALL be an output, 1 bit wide: high in RECV or WRITE.
REQ-014 Port done SHALL be an output, 1 bit wide: a 1-cycle pulse at load completion.
REQ-015 Port err SHALL be an output, 1 bit wide: a 1-cycle pulse when start is rejected.
REQ-016 Port cpu_hold SHALL be an output, 1 bit wide: keeps the core stalled until a load completes.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, RECV, WRITE, DONE.
REQ-018 In IDLE, start with 1 <= num_words <= DEPTH SHALL latch num_words, clear word_cnt and byte_cnt, and move to RECV next cycle.
REQ-019 In IDLE, start with num_words == 0 SHALL move to DONE without any memory write.
REQ-020 In IDLE, start with num_words > DEPTH SHALL pulse err for 1 cycle, stay in IDLE, and perform no writes.
REQ-021 Start SHALL be ignored in RECV, WRITE and DONE; in-flight counters and the latched count SHALL be unaffected.
REQ-022 In_ready SHALL be 1 only in RECV and SHALL be combinationally independent of in_valid.
REQ-023 In RECV, each accepted byte SHALL be stored to assembly bits [8*byte_cnt+7 : 8*byte_cnt] (little-endian), after which byte_cnt increments modulo 4.
REQ-024 Acceptance of the byte with byte_cnt == 3 SHALL move the FSM to WRITE on the next cycle.
REQ-025 WRITE SHALL last exactly 1 cycle with mem_we=1, mem_waddr=word_cnt, and mem_wdata=assembled word.
REQ-026 Write latency SHALL be exactly 1 clk from acceptance of the 4th byte to mem_we high.
REQ-027 In WRITE, word_cnt SHALL increment; if the pre-increment word_cnt+1 == latched count the FSM SHALL go to DONE, otherwise to RECV.
REQ-028 Peak throughput SHALL be 1 word per 5 cycles; in_valid low in RECV SHALL stall indefinitely with no timeout.
REQ-029 DONE SHALL last 1 cycle: done=1, cpu_hold cleared, then return to IDLE.
REQ-030 Mem_we SHALL be 0 in every state other than WRITE; mem_waddr and mem_wdata SHALL hold their last values outside WRITE.
REQ-031 Cpu_hold SHALL be 1 from reset until the first DONE, SHALL be set again on any accepted start, and SHALL clear in DONE.
REQ-032 Word_cnt SHALL never exceed DEPTH-1 on mem_waddr; addresses written SHALL be 0 .. N-1 in order.

Reset
REQ-033 While rst_n is low at a rising clk edge, the state SHALL become IDLE and byte_cnt, word_cnt, the assembly register, mem_waddr and mem_wdata SHALL become 0.
REQ-034 While rst_n is low at a rising clk edge, outputs SHALL be in_ready=0, mem_we=0, busy=0, done=0, err=0, cpu_hold=1.
REQ-035 Reset asserted mid-load, including during WRITE, SHALL discard the partial word, issue no further write, and restart cleanly on the next start.

Verification
REQ-036 The bench SHALL cover: start, num_words=1, bytes 13,00,00,00 -> one mem_we at addr 0, data 0x00000013, done 1 cycle later, cpu_hold falls.
REQ-037 The bench SHALL cover: num_words=3, 12 bytes streamed back-to-back -> writes at addr 0,1,2 spaced exactly 5 cycles apart, little-endian words correct.
REQ-038 The bench SHALL cover: in_valid randomly deasserted during num_words=2 -> same 2 writes, no dropped or duplicated bytes, in_ready low in WRITE.
REQ-039 The bench SHALL cover: num_words=0 -> done pulse, no mem_we; num_words=33 -> err pulse, FSM stays IDLE, cpu_hold remains 1.
REQ-040 The bench SHALL cover: rst_n low after 2 bytes of word 1 -> no write for word 1; a new start with num_words=1 rewrites addr 0 correctly.
REQ-041 The bench SHALL cover: start pulsed during RECV -> ignored, latched count unchanged, exactly the original number of writes.
